// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, parity sense and config types shared by the UART transmitter and receiver
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int BAUD_W_DEF = 20;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_e;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;
  typedef struct packed {
    logic [7:0] data;
    logic       eight;
    logic       pen;
    parity_e    ohel;
  } tx_cfg_t;
  function automatic logic parity(input logic [7:0] d, input logic eight, input parity_e sense);
    return (^(eight ? d : {1'b0, d[6:0]})) ^ (sense == ODD);
  endfunction
endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: counts 0..baud while enabled and pulses btu on the last count of each bit period
module tx_bit_timer #(
  parameter int BAUD_W = uart_pkg::BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [BAUD_W-1:0] baud,
  output logic              btu
);
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  assign btu   = enable && (cnt_q == baud);
  assign cnt_d = (!enable || btu) ? '0 : cnt_q + 1'b1;
  // bit-time counter, held at zero while disabled so each frame starts a full period
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/tx_engine.sv
// tx_engine: UART transmitter producing 11-bit frames (start, 7/8 data, optional parity, stop)
module tx_engine import uart_pkg::*; #(
  parameter int BAUD_W = BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        data,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud,
  output logic              tx,
  output logic              tx_rdy
);
  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  tx_cfg_t               cfg_q, cfg_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic                  btu, par, slot7, slot8;

  tx_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(state_q == SEND),
    .baud  (baud_q),
    .btu   (btu)
  );

  assign par    = parity(cfg_q.data, cfg_q.eight, cfg_q.ohel);
  assign slot7  = cfg_q.eight ? cfg_q.data[7] : (cfg_q.pen ? par : 1'b1);
  assign slot8  = (cfg_q.eight && cfg_q.pen) ? par : 1'b1;
  assign tx     = sr_q[0];
  assign tx_rdy = (state_q == IDLE);

  // accept a frame when idle; slots 7/8 come from the latched config and are spliced in on the first shift
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cfg_d     = cfg_q;
    baud_d    = baud_q;
    if (state_q == IDLE && load) begin
      state_d   = SEND;
      sr_d      = {3'b111, data[6:0], 1'b0};
      bit_cnt_d = '0;
      cfg_d     = '{data: data, eight: eight, pen: pen, ohel: parity_e'(ohel)};
      baud_d    = baud;
    end else if (state_q == SEND && btu) begin
      if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
        state_d   = IDLE;
        sr_d      = '1;
        bit_cnt_d = '0;
      end else begin
        sr_d      = {1'b1, sr_q[FRAME_BITS-1:1]};
        if (bit_cnt_q == 4'd0) sr_d[8:7] = {slot8, slot7};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  // frame state, shift register and latched config
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '1;
      bit_cnt_q <= '0;
      cfg_q     <= '0;
      baud_q    <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_q     <= cfg_d;
      baud_q    <= baud_d;
    end
endmodule

// File: tb/tb_tx_engine.sv
// tb_tx_engine: directed frame vectors plus back-to-back, mid-frame load and mid-frame reset sequences
module tb_tx_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  data = '0;
  logic        eight = 1'b0;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic [19:0] baud = '0;
  logic        tx, tx_rdy;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [19:0] baud;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[6];

  tx_engine #(.BAUD_W(20)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .data  (data),
    .eight (eight),
    .pen   (pen),
    .ohel  (ohel),
    .baud  (baud),
    .tx    (tx),
    .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_rdy();
    for (int k = 0; k < 200 && tx_rdy !== 1'b1; k++) step();
    chk("rdy_wait", tx_rdy, 1);
  endtask

  task automatic apply(input vec_t v);
    data  = v.data;
    eight = v.eight;
    pen   = v.pen;
    ohel  = v.ohel;
    baud  = v.baud;
  endtask

  task automatic run_frame(input vec_t v, input bit pulse);
    wait_rdy();
    apply(v);
    load = 1'b1;
    step();
    load  = 1'b0;
    data  = ~v.data;
    eight = ~v.eight;
    pen   = ~v.pen;
    ohel  = ~v.ohel;
    baud  = v.baud + 20'd5;
    for (int i = 0; i < 11; i++)
      for (int c = 0; c <= int'(v.baud); c++) begin
        chk($sformatf("tx_bit%0d", i), tx, v.frame[i]);
        chk("busy", tx_rdy, 0);
        if (pulse && i == 3 && c == 0) begin
          load = 1'b1;
          data = 8'hFF;
        end else load = 1'b0;
        step();
      end
    chk("end_rdy", tx_rdy, 1);
    chk("end_tx", tx, 1);
    step();
    chk("no_queued_rdy", tx_rdy, 1);
    chk("no_queued_tx", tx, 1);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 20'd3, 11'b11010101010};
    vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 20'd3, 11'b11110000010};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 20'd0, 11'b10000000110};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 20'd1, 11'b11101001010};
    vecs[4] = '{8'hB5, 1'b1, 1'b1, 1'b1, 20'd2, 11'b10101101010};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 20'd0, 11'b11000000000};

    step();
    step();
    chk("reset_tx", tx, 1);
    chk("reset_rdy", tx_rdy, 1);
    reset = 1'b0;

    for (int n = 0; n < 6; n++) run_frame(vecs[n], n == 0 || n == 4);

    wait_rdy();
    apply(vecs[2]);
    load = 1'b1;
    step();
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("b2b_bit%0d", k), tx, vecs[2].frame[k]);
      step();
    end
    chk("b2b_rdy_high", tx_rdy, 1);
    chk("b2b_idle_tx", tx, 1);
    step();
    chk("b2b_second_busy", tx_rdy, 0);
    chk("b2b_second_start", tx, 0);
    load = 1'b0;
    wait_rdy();

    apply(vecs[3]);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (10) step();
    chk("pre_reset_bit5", tx, 0);
    reset = 1'b1;
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_rdy", tx_rdy, 1);
    step();
    reset = 1'b0;
    run_frame(vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_engine.md
TX_ENGINE -- requirements
Module: tx_engine

Interface
REQ-001 Parameter BAUD_W, default 20, width of baud divisor input and bit-time counter.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  single-cycle request to transmit data; honoured only while tx_rdy=1.
REQ-005 data  input  8  byte to transmit, sampled on the accepting edge.
REQ-006 eight  input  1  1 = 8 data bits, 0 = 7 data bits (d0..d6).
REQ-007 pen  input  1  1 = parity bit enabled.
REQ-008 ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-009 baud  input  BAUD_W  bit period minus one, in clk cycles.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 tx_rdy  output  1  1 = idle, may accept load; registered.

Function
REQ-012 Bit period SHALL be baud+1 clocks; bit-time counter counts 0..baud, asserts internal btu at count==baud, returns to 0 same edge.
REQ-013 On an edge with load=1 and tx_rdy=1, block SHALL latch data, eight, pen, ohel, baud, load an 11-bit shift register, clear both counters, drop tx_rdy.
REQ-014 Every frame SHALL be exactly 11 bit periods, LSB first: start(0), d0..d6, slot7, slot8, stop(1).
REQ-015 slot7 = d7 if eight=1; else parity if pen=1; else 1.
REQ-016 slot8 = parity if eight=1 and pen=1; else 1.
REQ-017 parity = XOR of transmitted data bits (7 or 8), inverted when ohel=1.
REQ-018 tx SHALL equal shift-register bit 0; start bit SHALL appear on tx the edge after acceptance (latency 1 clock).
REQ-019 On each btu while busy, shift register SHALL shift right filling with 1, bit counter SHALL increment.
REQ-020 On the 11th btu, block SHALL return to idle: tx_rdy=1, tx=1, counters 0, next edge.
REQ-021 load while tx_rdy=0 SHALL be ignored with no effect on the current frame.
REQ-022 load on the first idle cycle after a frame SHALL be accepted (back-to-back frames, no gap beyond one clock).
REQ-023 Changes to data/eight/pen/ohel/baud during a frame SHALL not affect it.
REQ-024 baud=0 SHALL yield 1-clock bit periods, 11-clock frames.
REQ-025 States: IDLE (tx_rdy=1, counters held 0) and SEND (counting); IDLE->SEND on accepted load, SEND->IDLE on 11th btu; no other transitions.

Reset
REQ-026 reset SHALL force tx=1, tx_rdy=1, state IDLE, shift register all ones, both counters 0, latched config 0, at any time including mid-frame.
REQ-027 After reset deassertion, a load in the first cycle SHALL be accepted.

Structure
REQ-028 Shared package uart_pkg SHALL hold FRAME_BITS=11, BAUD_W default, and parity-sense encoding (ODD=1, EVEN=0), shared with the receiver.
REQ-029 Bit-time counter SHALL be a sub-module tx_bit_timer (inputs enable, baud; output btu), reusable by the receiver.
REQ-030 Parity generation and slot selection SHALL be combinational from the latched inputs.

Verification
REQ-031 baud=3, eight=1, pen=0, load data=0x55 -> tx 0,1,0,1,0,1,0,1,0,1,1, 4 clocks each; tx_rdy low exactly 44 clocks.
REQ-032 baud=3, eight=0, pen=1, ohel=1, data=0x41 -> tx 0,1,0,0,0,0,0,1,1,1,1 (odd parity=1 in slot7).
REQ-033 baud=0, eight=1, pen=1, ohel=0, data=0x03 -> tx 0,1,1,0,0,0,0,0,0,0,1 over 11 clocks; load held high -> second frame starts 1 clock after tx_rdy rises.
REQ-034 load pulsed mid-frame with data=0xFF -> current frame unchanged, 0xFF never sent.
REQ-035 reset asserted at bit 5 of a frame -> tx=1 and tx_rdy=1 immediately; next load sends a clean full frame.
